cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single result broadcast channel (CDB) between the ALU reservation-station result path and the load/store buffer result path.
- Each requester pushes results into a private small FIFO. A round-robin arbiter pops one head per cycle onto a registered CDB output.
- The CDB output is consumed by the ROB, the reservation stations and the LSB.
- A misprediction flush from the ROB discards every queued, not-yet-broadcast result.

Parameters:
- ROB_WIDTH, 4, ROB index width.
- ADDR_WIDTH, 32, PC width.
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, ≥2.

Ports:
- Sys_clk  in  1  clock; all state updates on the rising edge.
- Sys_rst  in  1  reset, synchronous, active-high.
- Sys_rdy  in  1  global enable; low = freeze.
- ROB2ARB_flush  in  1  misprediction flush.
- RS2ARB_en  in  1  ALU result valid.
- RS2ARB_ROB_index  in  ROB_WIDTH  ALU result tag.
- RS2ARB_value  in  32  rd value or branch taken flag.
- RS2ARB_next_pc  in  ADDR_WIDTH  resolved next pc.
- ARB2RS_ready  out  1  ALU FIFO can accept.
- LSB2ARB_en  in  1  load/store result valid.
- LSB2ARB_ROB_index  in  ROB_WIDTH  load/store result tag.
- LSB2ARB_value  in  32  load data; 0 for stores.
- ARB2LSB_ready  out  1  LSB FIFO can accept.
- CDB_en  out  1  broadcast valid, registered.
- CDB_ROB_index  out  ROB_WIDTH  broadcast tag.
- CDB_value  out  32  broadcast value.
- CDB_next_pc  out  ADDR_WIDTH  next pc; 0 for LSB results.
- CDB_from_lsb  out  1  source of the broadcast: 1 = LSB, 0 = ALU.

Behaviour:
- Clocking and reset: one clock, Sys_clk. Reset Sys_rst is synchronous and active-high.
- Reset values:
  - Both FIFOs empty (pointers and counts 0).
  - last_grant = LSB, so the ALU wins the first contention.
  - CDB_en = 0; CDB_ROB_index, CDB_value, CDB_next_pc, CDB_from_lsb all 0.
- Ready signals: ARB2x_ready = Sys_rdy && count_x < FIFO_DEPTH. Readiness is conservative: a same-cycle pop does not free a slot for the current cycle.
- Push: occurs on an edge where x_en && ARB2x_ready && !ROB2ARB_flush && !Sys_rst. If en is asserted while ready is low, the data is dropped; it is the requester's fault, and an assertion must flag it.
- Arbitration is combinational, on FIFO heads only, with no input bypass:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source opposite to last_grant.
  - Neither non-empty: no grant.
- Broadcast, on an edge with Sys_rdy=1 and no flush:
  - With a grant: pop the head, register it onto the CDB outputs, set CDB_en=1, last_grant ← granted source.
  - Without a grant: CDB_en ← 0; data outputs hold their previous value.
- Latency: an entry accepted at edge N is visible on the CDB after edge N+1 at the earliest. The CDB_en pulse lasts exactly one cycle per entry.
- Throughput:
  - One broadcast per cycle.
  - Under sustained contention, grants alternate ALU, LSB, ALU, ...
  - No requester waits more than one broadcast slot once its FIFO is non-empty.
- Flush, when ROB2ARB_flush=1 at an edge (regardless of Sys_rdy):
  - Both FIFOs are emptied.
  - The same-cycle incoming push is discarded.
  - CDB_en ← 0.
  - last_grant is unchanged.
  - Pushes resume on the next cycle.
- Sys_rdy=0: no push, no pop, no pointer change. All CDB outputs including CDB_en hold their registered values. Consumers gate on Sys_rdy themselves.
- Reset mid-operation: reset takes priority over flush and push. Queued entries are lost, and outputs take reset values on the next edge.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits. Full = count==FIFO_DEPTH; empty = count==0.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.

Decomposition:
- Shared package or header:
  - Width constants ROB_WIDTH, ADDR_WIDTH, EX_ROB_WIDTH.
  - A result-entry layout constant: {ROB_index, value, next_pc}, width ROB_WIDTH+32+ADDR_WIDTH.
  - Source-ID localparams SRC_ALU=0, SRC_LSB=1.
- One natural sub-module: result_fifo.
  - Parameterised on data width and depth.
  - Ports: push, pop, flush, din, dout, full, empty, count.
  - Instantiated twice; the LSB instance ties next_pc to 0.
  - The arbiter and output register stay in cdb_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> CDB_en=0 throughout; both readies=1; all outputs 0.
- Single ALU push {idx=3, value=0x12345678, next_pc=0x104} at edge N -> CDB_en=1 only in the cycle after edge N+1, with CDB_from_lsb=0 and the fields echoed exactly.
- Both sources push every cycle for 6 cycles (ALU idx 1,2,3..., LSB idx 9,10,11...) -> CDB sequence ALU1, LSB9, ALU2, LSB10, ...; readies drop when count=2; no entry lost or duplicated.
- Fill both FIFOs (2 each), then assert ROB2ARB_flush for one edge with a concurrent push -> CDB_en=0 next cycle; no flushed or concurrent entry is ever broadcast; a push in the following cycle broadcasts normally.
- LSB FIFO holding 2 entries, Sys_rdy low for 3 cycles -> CDB outputs frozen, readies=0, counts unchanged; after Sys_rdy rises both entries drain on consecutive cycles.
- Assert Sys_rst while both FIFOs are non-empty and CDB_en=1 -> next cycle CDB_en=0 and counts 0; the first contention after reset is granted to the ALU.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, result-entry layout and source IDs for the CDB arbiter
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH    = 4;
    localparam int ADDR_WIDTH   = 32;
    // ROB index plus the wrap bit used by consumers that compare ages
    localparam int EX_ROB_WIDTH = ROB_WIDTH + 1;
    localparam int VALUE_WIDTH  = 32;

    // Result entry layout, MSB first: {ROB_index, value, next_pc}
    localparam int ENTRY_WIDTH  = ROB_WIDTH + VALUE_WIDTH + ADDR_WIDTH;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// rtl/cdb_arbiter_result_fifo.sv - small per-requester result FIFO with synchronous flush
// Ports: clk/rst (sync, active-high), push/pop strobes, flush (empties the queue),
//        din/dout (dout is the current head), full, empty, count.
// The caller never pushes when full nor pops when empty.
module result_fifo #(
    parameter int DATA_WIDTH = 68,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset; a stray write during flush lands in a slot that is already free
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin sharing of the CDB between the ALU and LSB result paths
// Ports: Sys_clk, Sys_rst (sync, active-high), Sys_rdy (low = freeze), ROB2ARB_flush;
//        RS2ARB_* / ARB2RS_ready : ALU result push interface;
//        LSB2ARB_* / ARB2LSB_ready : load/store result push interface;
//        CDB_* : registered broadcast, CDB_from_lsb tells which source it came from.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
    parameter int ADDR_WIDTH = cdb_arbiter_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  ROB2ARB_flush,
    input  logic                  RS2ARB_en,
    input  logic [ROB_WIDTH-1:0]  RS2ARB_ROB_index,
    input  logic [31:0]           RS2ARB_value,
    input  logic [ADDR_WIDTH-1:0] RS2ARB_next_pc,
    output logic                  ARB2RS_ready,
    input  logic                  LSB2ARB_en,
    input  logic [ROB_WIDTH-1:0]  LSB2ARB_ROB_index,
    input  logic [31:0]           LSB2ARB_value,
    output logic                  ARB2LSB_ready,
    output logic                  CDB_en,
    output logic [ROB_WIDTH-1:0]  CDB_ROB_index,
    output logic [31:0]           CDB_value,
    output logic [ADDR_WIDTH-1:0] CDB_next_pc,
    output logic                  CDB_from_lsb
);

    import cdb_arbiter_pkg::*;

    localparam int ENTRY_W = ROB_WIDTH + 32 + ADDR_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [ENTRY_W-1:0] alu_din, alu_dout, lsb_din, lsb_dout, head;
    logic               alu_full, alu_empty, lsb_full, lsb_empty;
    logic [CNT_W-1:0]   alu_count, lsb_count;
    logic               alu_push, alu_pop, lsb_push, lsb_pop;
    logic               grant_valid, grant_src, last_grant;
    logic               broadcast;

    // Readiness ignores a same-cycle pop so ready never depends on the grant path
    assign ARB2RS_ready  = Sys_rdy && !alu_full;
    assign ARB2LSB_ready = Sys_rdy && !lsb_full;

    assign alu_push = RS2ARB_en  && ARB2RS_ready  && !ROB2ARB_flush;
    assign lsb_push = LSB2ARB_en && ARB2LSB_ready && !ROB2ARB_flush;

    assign alu_din = {RS2ARB_ROB_index, RS2ARB_value, RS2ARB_next_pc};
    assign lsb_din = {LSB2ARB_ROB_index, LSB2ARB_value, {ADDR_WIDTH{1'b0}}};

    // Arbitration looks only at FIFO heads; under contention the source
    // that did not win last time gets the slot
    assign grant_valid = !alu_empty || !lsb_empty;

    always_comb begin
        grant_src = SRC_ALU;
        if (!alu_empty && !lsb_empty) grant_src = ~last_grant;
        else if (!lsb_empty)          grant_src = SRC_LSB;
    end

    assign broadcast = Sys_rdy && !ROB2ARB_flush && grant_valid;
    assign alu_pop   = broadcast && (grant_src == SRC_ALU);
    assign lsb_pop   = broadcast && (grant_src == SRC_LSB);
    assign head      = (grant_src == SRC_LSB) ? lsb_dout : alu_dout;

    result_fifo #(.DATA_WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk   (Sys_clk),
        .rst   (Sys_rst),
        .push  (alu_push),
        .pop   (alu_pop),
        .flush (ROB2ARB_flush),
        .din   (alu_din),
        .dout  (alu_dout),
        .full  (alu_full),
        .empty (alu_empty),
        .count (alu_count)
    );

    result_fifo #(.DATA_WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk   (Sys_clk),
        .rst   (Sys_rst),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .flush (ROB2ARB_flush),
        .din   (lsb_din),
        .dout  (lsb_dout),
        .full  (lsb_full),
        .empty (lsb_empty),
        .count (lsb_count)
    );

    // Output register; data fields hold when nothing is broadcast, and
    // everything (including CDB_en) holds while Sys_rdy is low
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            CDB_en        <= 1'b0;
            CDB_ROB_index <= '0;
            CDB_value     <= '0;
            CDB_next_pc   <= '0;
            CDB_from_lsb  <= 1'b0;
            last_grant    <= SRC_LSB;
        end else if (ROB2ARB_flush) begin
            CDB_en <= 1'b0;
        end else if (Sys_rdy) begin
            if (grant_valid) begin
                CDB_en                                   <= 1'b1;
                {CDB_ROB_index, CDB_value, CDB_next_pc}  <= head;
                CDB_from_lsb                             <= grant_src;
                last_grant                               <= grant_src;
            end else begin
                CDB_en <= 1'b0;
            end
        end
    end

    // A requester asserting en while not ready loses that result
    a_alu_no_drop: assert property (@(posedge Sys_clk) disable iff (Sys_rst)
        RS2ARB_en |-> ARB2RS_ready);
    a_lsb_no_drop: assert property (@(posedge Sys_clk) disable iff (Sys_rst)
        LSB2ARB_en |-> ARB2LSB_ready);
    a_alu_count: assert property (@(posedge Sys_clk) disable iff (Sys_rst)
        alu_count <= CNT_W'(FIFO_DEPTH));
    a_lsb_count: assert property (@(posedge Sys_clk) disable iff (Sys_rst)
        lsb_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int DEPTH = 2;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst, Sys_rdy, ROB2ARB_flush;
    logic        RS2ARB_en, LSB2ARB_en;
    logic [3:0]  RS2ARB_ROB_index, LSB2ARB_ROB_index;
    logic [31:0] RS2ARB_value, LSB2ARB_value, RS2ARB_next_pc;
    logic        ARB2RS_ready, ARB2LSB_ready;
    logic        CDB_en, CDB_from_lsb;
    logic [3:0]  CDB_ROB_index;
    logic [31:0] CDB_value, CDB_next_pc;

    always #5 Sys_clk = ~Sys_clk;

    cdb_arbiter #(.ROB_WIDTH(4), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .Sys_clk           (Sys_clk),
        .Sys_rst           (Sys_rst),
        .Sys_rdy           (Sys_rdy),
        .ROB2ARB_flush     (ROB2ARB_flush),
        .RS2ARB_en         (RS2ARB_en),
        .RS2ARB_ROB_index  (RS2ARB_ROB_index),
        .RS2ARB_value      (RS2ARB_value),
        .RS2ARB_next_pc    (RS2ARB_next_pc),
        .ARB2RS_ready      (ARB2RS_ready),
        .LSB2ARB_en        (LSB2ARB_en),
        .LSB2ARB_ROB_index (LSB2ARB_ROB_index),
        .LSB2ARB_value     (LSB2ARB_value),
        .ARB2LSB_ready     (ARB2LSB_ready),
        .CDB_en            (CDB_en),
        .CDB_ROB_index     (CDB_ROB_index),
        .CDB_value         (CDB_value),
        .CDB_next_pc       (CDB_next_pc),
        .CDB_from_lsb      (CDB_from_lsb)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] val;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit          aen;
        logic [3:0]  aidx;
        bit          len;
        logic [3:0]  lidx;
        bit          exp_ra;
        bit          exp_rl;
        bit          exp_en;
        bit          exp_lsb;
        logic [3:0]  exp_idx;
        logic [31:0] exp_val;
        logic [31:0] exp_pc;
    } vec_t;

    // Reference model: two queues, a last-winner flag and the broadcast register
    ent_t aq[$];
    ent_t lq[$];
    bit   m_last;
    bit   m_en;
    bit   m_from;
    ent_t m_cdb;

    int n_cmp  = 0;
    int n_fail = 0;
    bit s_ra, s_rl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [3:0] i, input logic [31:0] v, input logic [31:0] p);
        ent_t e;
        e.idx = i; e.val = v; e.pc = p;
        return e;
    endfunction

    function automatic ent_t alu_ent(input int i);
        return mk(4'(i), 32'hA000_0000 | 32'(i), 32'h1000 + 32'(i) * 4);
    endfunction

    function automatic ent_t lsb_ent(input int i);
        return mk(4'(i), 32'hB000_0000 | 32'(i), 32'h0);
    endfunction

    function automatic vec_t mk_vec(input bit aen, input int ai, input bit len, input int li,
                                    input bit era, input bit erl, input bit een, input bit elsb,
                                    input int eidx, input bit ezero);
        vec_t v;
        ent_t e;
        e = elsb ? lsb_ent(eidx) : alu_ent(eidx);
        v.aen = aen; v.aidx = 4'(ai); v.len = len; v.lidx = 4'(li);
        v.exp_ra = era; v.exp_rl = erl; v.exp_en = een; v.exp_lsb = ezero ? 1'b0 : elsb;
        v.exp_idx = ezero ? 4'h0 : e.idx;
        v.exp_val = ezero ? 32'h0 : e.val;
        v.exp_pc  = ezero ? 32'h0 : e.pc;
        return v;
    endfunction

    // One clock: drive inputs, check readiness before the edge, advance the
    // model at the edge and compare the registered outputs just after it
    task automatic step(input bit rst, input bit rdy, input bit flush,
                        input bit aen, input ent_t a, input bit len, input ent_t l,
                        input bit chk_rdy);
        bit ra, rl, ae, le, an, ln, src;
        ra = rdy && (aq.size() < DEPTH);
        rl = rdy && (lq.size() < DEPTH);
        ae = aen && ra;
        le = len && rl;
        Sys_rst = rst; Sys_rdy = rdy; ROB2ARB_flush = flush;
        RS2ARB_en = ae; RS2ARB_ROB_index = a.idx; RS2ARB_value = a.val; RS2ARB_next_pc = a.pc;
        LSB2ARB_en = le; LSB2ARB_ROB_index = l.idx; LSB2ARB_value = l.val;
        #1;
        s_ra = ARB2RS_ready;
        s_rl = ARB2LSB_ready;
        if (chk_rdy) begin
            chk("rs_ready", s_ra, ra);
            chk("lsb_ready", s_rl, rl);
        end
        @(posedge Sys_clk);
        if (rst) begin
            aq.delete(); lq.delete();
            m_last = 1'b1; m_en = 1'b0; m_from = 1'b0; m_cdb = mk(0, 0, 0);
        end else if (flush) begin
            aq.delete(); lq.delete();
            m_en = 1'b0;
        end else if (rdy) begin
            an = aq.size() > 0;
            ln = lq.size() > 0;
            if (an || ln) begin
                src = (an && ln) ? !m_last : ln;
                m_cdb  = src ? lq.pop_front() : aq.pop_front();
                m_from = src;
                m_last = src;
                m_en   = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            if (ae) aq.push_back(a);
            if (le) lq.push_back(mk(l.idx, l.val, 32'h0));
        end
        #1;
        chk("cdb_en", CDB_en, m_en);
        chk("cdb_idx", CDB_ROB_index, m_cdb.idx);
        chk("cdb_value", CDB_value, m_cdb.val);
        chk("cdb_next_pc", CDB_next_pc, m_cdb.pc);
        chk("cdb_from_lsb", CDB_from_lsb, m_from);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, mk(0, 0, 0), 0, mk(0, 0, 0), 1);
    endtask

    vec_t tbl[10];
    ent_t z, snap;

    initial begin
        z = mk(0, 0, 0);
        // Both requesters retry every cycle until accepted; sequence must alternate A,L,A,L...
        tbl[0] = mk_vec(1, 1, 1,  9, 1, 1, 0, 0,  0, 1);
        tbl[1] = mk_vec(1, 2, 1, 10, 1, 1, 1, 0,  1, 0);
        tbl[2] = mk_vec(1, 3, 0,  0, 1, 0, 1, 1,  9, 0);
        tbl[3] = mk_vec(0, 0, 1, 11, 0, 1, 1, 0,  2, 0);
        tbl[4] = mk_vec(1, 4, 0,  0, 1, 0, 1, 1, 10, 0);
        tbl[5] = mk_vec(0, 0, 1, 12, 0, 1, 1, 0,  3, 0);
        tbl[6] = mk_vec(0, 0, 0,  0, 1, 0, 1, 1, 11, 0);
        tbl[7] = mk_vec(0, 0, 0,  0, 1, 1, 1, 0,  4, 0);
        tbl[8] = mk_vec(0, 0, 0,  0, 1, 1, 1, 1, 12, 0);
        tbl[9] = mk_vec(0, 0, 0,  0, 1, 1, 0, 1, 12, 0);

        Sys_rst = 1; Sys_rdy = 0; ROB2ARB_flush = 0; RS2ARB_en = 0; LSB2ARB_en = 0;
        RS2ARB_ROB_index = 0; RS2ARB_value = 0; RS2ARB_next_pc = 0;
        LSB2ARB_ROB_index = 0; LSB2ARB_value = 0;

        // Reset, then idle
        step(1, 1, 0, 0, z, 0, z, 0);
        idle(5);

        // Sustained contention from a fresh reset
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, tbl[i].aen, alu_ent(tbl[i].aidx), tbl[i].len, lsb_ent(tbl[i].lidx), 1);
            chk($sformatf("tbl%0d_rs_ready", i), s_ra, tbl[i].exp_ra);
            chk($sformatf("tbl%0d_lsb_ready", i), s_rl, tbl[i].exp_rl);
            chk($sformatf("tbl%0d_en", i), CDB_en, tbl[i].exp_en);
            chk($sformatf("tbl%0d_from_lsb", i), CDB_from_lsb, tbl[i].exp_lsb);
            chk($sformatf("tbl%0d_idx", i), CDB_ROB_index, tbl[i].exp_idx);
            chk($sformatf("tbl%0d_value", i), CDB_value, tbl[i].exp_val);
            chk($sformatf("tbl%0d_pc", i), CDB_next_pc, tbl[i].exp_pc);
        end

        // Single ALU push: not visible after edge N, visible for exactly one cycle after N+1
        step(0, 1, 0, 1, mk(4'd3, 32'h1234_5678, 32'h104), 0, z, 1);
        chk("single_en_n", CDB_en, 1'b0);
        idle(1);
        chk("single_en_n1", CDB_en, 1'b1);
        chk("single_idx", CDB_ROB_index, 4'd3);
        chk("single_value", CDB_value, 32'h1234_5678);
        chk("single_pc", CDB_next_pc, 32'h104);
        chk("single_from_lsb", CDB_from_lsb, 1'b0);
        idle(1);
        chk("single_pulse", CDB_en, 1'b0);

        // Flush with queued entries and a concurrent push
        step(0, 1, 0, 1, alu_ent(5), 1, lsb_ent(5), 1);
        step(0, 1, 0, 1, alu_ent(6), 1, lsb_ent(6), 1);
        step(0, 1, 1, 1, alu_ent(7), 1, lsb_ent(7), 1);
        chk("flush_en", CDB_en, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("post_flush_en", CDB_en, 1'b0);
        end
        step(0, 1, 0, 1, alu_ent(8), 0, z, 1);
        idle(1);
        chk("after_flush_en", CDB_en, 1'b1);
        chk("after_flush_idx", CDB_ROB_index, 4'd8);
        idle(1);

        // Build up two LSB entries, then freeze for 3 cycles
        step(0, 1, 0, 1, alu_ent(1), 1, lsb_ent(1), 1);
        step(0, 1, 0, 1, alu_ent(2), 1, lsb_ent(2), 1);
        step(0, 1, 0, 0, z, 1, lsb_ent(3), 1);
        chk("pre_freeze_lsb_depth", lq.size(), DEPTH);
        snap = m_cdb;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, z, 0, z, 1);
            chk("freeze_rs_ready", s_ra, 1'b0);
            chk("freeze_lsb_ready", s_rl, 1'b0);
            chk("freeze_idx", CDB_ROB_index, snap.idx);
            chk("freeze_en", CDB_en, 1'b1);
        end
        idle(4);
        chk("drained_en", CDB_en, 1'b0);

        // Reset mid-operation, then first contention goes to the ALU
        step(0, 1, 0, 1, alu_ent(4), 1, lsb_ent(4), 1);
        step(0, 1, 0, 1, alu_ent(5), 1, lsb_ent(5), 1);
        step(1, 1, 0, 1, alu_ent(6), 1, lsb_ent(6), 1);
        chk("rst_en", CDB_en, 1'b0);
        chk("rst_value", CDB_value, 32'h0);
        step(0, 1, 0, 1, alu_ent(7), 1, lsb_ent(14), 1);
        idle(1);
        chk("rst_first_en", CDB_en, 1'b1);
        chk("rst_first_from_lsb", CDB_from_lsb, 1'b0);
        chk("rst_first_idx", CDB_ROB_index, 4'd7);
        idle(1);
        chk("rst_second_from_lsb", CDB_from_lsb, 1'b1);

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            bit r_rst, r_flush, r_rdy;
            r_rst   = ($urandom_range(0, 99) < 2);
            r_flush = ($urandom_range(0, 99) < 5);
            r_rdy   = ($urandom_range(0, 9) < 8);
            step(r_rst, r_rdy, r_flush,
                 1'($urandom_range(0, 1)), mk(4'($urandom), $urandom, $urandom),
                 1'($urandom_range(0, 1)), mk(4'($urandom), $urandom, 32'h0), 1);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
